// File: rtl/mips_mem_pkg.sv
// Shared constants and types for the MIPS32 instruction- and data-memory responders.
// Holds the FSM state encoding used by mips_dmem_responder.
package mips_mem_pkg;

    localparam int unsigned DEF_ADDR_W    = 10;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned WORD_BYTES    = 4;
    localparam int unsigned WORD_OFFSET_W = 2;
    localparam int unsigned WAIT_CNT_W    = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t RESP = 2'd2;

    // Instruction fetch works on byte PCs; both memories index by word.
    function automatic logic [31:0] byte_to_word_addr(input logic [31:0] byte_addr);
        return {{WORD_OFFSET_W{1'b0}}, byte_addr[31:WORD_OFFSET_W]};
    endfunction

endpackage

// File: rtl/mips_dmem_array.sv
// Single-port synchronous data RAM: write or registered read on each enabled edge.
// Contents and read register are deliberately left without reset.
module mips_dmem_array
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: a RAM array gets no reset; clearing it would force it out of block RAM into flops.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MIPS32 MEM stage: valid/ready request and response, WAIT_CYCLES wait states.
// Optional MIPS_DMEM_BOUNDS_CHECK_EN adds rsp_err and rejects addresses beyond the array depth.
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
`ifdef MIPS_DMEM_BOUNDS_CHECK_EN
    ,
    output logic              rsp_err
`endif
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LD = WAIT_CNT_W'(WAIT_CYCLES);

    state_t                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [31:0]             addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       rsp_data_q, rsp_data_d;
    logic                    from_mem_q, from_mem_d;

    logic                    accept;
    logic                    access;
    logic                    oor;
    logic                    acc_we;
    logic [31:0]             acc_addr;
    logic [DATA_W-1:0]       acc_wdata;
    logic [DATA_W-1:0]       mem_rdata;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

    // With zero wait states the access happens on the accept edge, straight from the request inputs.
    assign acc_we    = (state_q == IDLE) ? req_we    : we_q;
    assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

`ifdef MIPS_DMEM_BOUNDS_CHECK_EN
    logic err_q, err_d;

    assign oor   = |acc_addr[31:ADDR_W];
    assign err_d = access ? oor : err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    logic unused_addr_hi;

    assign oor            = 1'b0;
    assign unused_addr_hi = ^acc_addr[31:ADDR_W];
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        from_mem_d = from_mem_q;
        access     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = WAIT_LD;
                    if (WAIT_LD == '0) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == WAIT_CNT_W'(1)) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Loads return the RAM's read register; stores echo data; rejected requests return zero.
        if (access) begin
            from_mem_d = !acc_we && !oor;
            rsp_data_d = (acc_we && !oor) ? acc_wdata : '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            from_mem_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            from_mem_q <= from_mem_d;
        end
    end

    mips_dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .en    (access && !oor && !rst),
        .we    (acc_we),
        .addr  (acc_addr[ADDR_W-1:0]),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    assign rsp_rdata = from_mem_q ? mem_rdata : rsp_data_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench for mips_dmem_responder: one instance with two wait states, one with none.
// Honours MIPS_DMEM_BOUNDS_CHECK_EN when the design is built with it.
module tb_mips_dmem_responder;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int W_A    = 2;
    localparam int W_B    = 0;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              sel       = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_we    = 1'b0;
    logic [31:0]       req_addr  = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_ready = 1'b0;

    logic              ready_a, valid_a, busy_a;
    logic              ready_b, valid_b, busy_b;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              req_ready, rsp_valid, busy;
    logic [DATA_W-1:0] rsp_rdata;
`ifdef MIPS_DMEM_BOUNDS_CHECK_EN
    logic              err_a, err_b, rsp_err;
`endif

    exp_t        exp_q[$];
    logic [31:0] model_a[int];
    logic [31:0] model_b[int];
    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mips_dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(W_A)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid & ~sel),
        .req_ready (ready_a),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (valid_a),
        .rsp_ready (rsp_ready & ~sel),
        .rsp_rdata (rdata_a),
        .busy      (busy_a)
`ifdef MIPS_DMEM_BOUNDS_CHECK_EN
        ,
        .rsp_err   (err_a)
`endif
    );

    mips_dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(W_B)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid & sel),
        .req_ready (ready_b),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (valid_b),
        .rsp_ready (rsp_ready & sel),
        .rsp_rdata (rdata_b),
        .busy      (busy_b)
`ifdef MIPS_DMEM_BOUNDS_CHECK_EN
        ,
        .rsp_err   (err_b)
`endif
    );

    assign req_ready = sel ? ready_b : ready_a;
    assign rsp_valid = sel ? valid_b : valid_a;
    assign rsp_rdata = sel ? rdata_b : rdata_a;
    assign busy      = sel ? busy_b  : busy_a;
`ifdef MIPS_DMEM_BOUNDS_CHECK_EN
    assign rsp_err   = sel ? err_b   : err_a;
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: applies the request to the selected instance's memory image.
    task automatic push_exp(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   idx;
        logic oor;
        idx = int'(addr[ADDR_W-1:0]);
`ifdef MIPS_DMEM_BOUNDS_CHECK_EN
        oor = |addr[31:ADDR_W];
`else
        oor = 1'b0;
`endif
        e.err = oor;
        if (oor) begin
            e.data = '0;
        end else if (we) begin
            e.data = wdata;
            if (sel) model_b[idx] = wdata;
            else     model_a[idx] = wdata;
        end else begin
            e.data = sel ? model_b[idx] : model_a[idx];
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            exp_t e;
            check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.data);
`ifdef MIPS_DMEM_BOUNDS_CHECK_EN
                check("rsp_err", 32'(rsp_err), 32'(e.err));
`endif
            end
        end
    end

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int t_acc);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        t_acc     = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                t_acc = cyc + 1;
                push_exp(we, addr, wdata);
                break;
            end
        end
        if (t_acc < 0) check("req_accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(output int t_v);
        t_v = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                t_v = cyc;
                break;
            end
        end
        if (t_v < 0) check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t_acc, t_v, t_prev, ws;

        repeat (3) @(negedge clk);
        check("reset_req_ready_forced", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_busy_b", 32'(busy_b), 32'd0);

        // Store then load at two wait states.
        rsp_ready = 1'b1;
        send(1'b1, 32'd5, 32'h0000_00AA, t_acc);
        wait_valid(t_v);
        check("t1_store_latency", 32'(t_v - t_acc), 32'(W_A));
        send(1'b0, 32'd5, 32'h0, t_acc);
        wait_valid(t_v);
        check("t1_load_latency", 32'(t_v - t_acc), 32'(W_A));

        // Zero wait states on the second instance.
        @(posedge clk);
        #1 sel = 1'b1;
        send(1'b1, 32'd3, 32'h1234_5678, t_acc);
        wait_valid(t_v);
        send(1'b0, 32'd3, 32'h0, t_acc);
        wait_valid(t_v);
        check("t2_load_latency", 32'(t_v - t_acc), 32'(W_B));
        check("t2_req_ready_in_resp", 32'(req_ready), 32'd0);

        // Response backpressure.
        @(posedge clk);
        #1;
        sel       = 1'b0;
        rsp_ready = 1'b0;
        send(1'b0, 32'd5, 32'h0, t_acc);
        wait_valid(t_v);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("t3_valid_held", 32'(rsp_valid), 32'd1);
            check("t3_rdata_held", rsp_rdata, 32'h0000_00AA);
            check("t3_req_ready", 32'(req_ready), 32'd0);
            check("t3_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_idle_busy", 32'(busy), 32'd0);
        check("t3_idle_valid", 32'(rsp_valid), 32'd0);
        check("t3_idle_ready", 32'(req_ready), 32'd1);

        // Address beyond the array depth.
        send(1'b1, 32'h0000_0405, 32'hDEAD_BEEF, t_acc);
        wait_valid(t_v);
        send(1'b0, 32'd5, 32'h0, t_acc);
        wait_valid(t_v);

        // Reset while a store is waiting, and a request presented during reset.
        send(1'b1, 32'd7, 32'h0000_0011, t_acc);
        wait_valid(t_v);
        send(1'b1, 32'd7, 32'h0000_0055, t_acc);
        rst = 1'b1;
        void'(exp_q.pop_back());
        model_a[7] = 32'h0000_0011;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'd7;
        req_wdata = 32'h0000_0099;
        @(negedge clk);
        check("t5_ready_in_reset", 32'(req_ready), 32'd0);
        check("t5_busy_in_reset", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_no_rsp", 32'(rsp_valid), 32'd0);
            check("t5_busy", 32'(busy), 32'd0);
        end
        send(1'b0, 32'd7, 32'h0, t_acc);
        wait_valid(t_v);

        // Back-to-back loads with req_valid held high, on both instances.
        for (int s = 0; s < 2; s++) begin
            @(posedge clk);
            #1 sel = (s == 1);
            ws = (s == 1) ? W_B : W_A;
            for (int n = 0; n < 4; n++) begin
                send(1'b1, 32'(20 + n), 32'hC0DE_0000 + 32'(16 * s + n), t_acc);
                wait_valid(t_v);
            end
            @(posedge clk);
            #1;
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = 32'd20;
            t_prev    = -1;
            for (int n = 0; n < 4; n++) begin
                t_acc = -1;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (req_ready) begin
                        t_acc = cyc + 1;
                        break;
                    end
                end
                if (t_acc < 0) begin
                    check("t6_accept_timeout", 32'(req_ready), 32'd1);
                end else begin
                    push_exp(1'b0, req_addr, 32'h0);
                    if (t_prev >= 0) check("t6_spacing", 32'(t_acc - t_prev), 32'(ws + 2));
                    t_prev = t_acc;
                end
                @(posedge clk);
                #1 req_addr = 32'(20 + n + 1);
            end
            req_valid = 1'b0;
            drain();
        end

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
